// File: rtl/tm1638_pkg.sv
// Shared TM1638 command-word kinds, opcodes, controller states and word packing.
// Pure definitions; no latency or flow control of its own.
package tm1638_pkg;

    localparam logic [1:0] KIND_CMD       = 2'b00;
    localparam logic [1:0] KIND_ADDR_DATA = 2'b01;
    localparam logic [1:0] KIND_READ      = 2'b10;

    localparam logic [7:0] CMD_DATA_FIXED = 8'h44;
    localparam logic [7:0] CMD_DISP_BASE  = 8'h80;
    localparam logic [7:0] CMD_ADDR_BASE  = 8'hC0;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_DATA_CMD,
        ST_DISP_CTRL,
        ST_IDLE,
        ST_EMIT,
        ST_GAP
    } state_t;

    function automatic logic [17:0] pack_word(input logic [1:0] kind,
                                              input logic [7:0] b1,
                                              input logic [7:0] b2);
        return {kind, b1, b2};
    endfunction

endpackage

// File: rtl/tm1638_display_ctrl_rr_picker.sv
// Round-robin dirty-address picker: first set bit after i_Last, wrapping at the top.
// Combinational, zero latency; the last-served pointer lives in the parent.
module rr_picker #(
    parameter int NUM_ADDR = 16,
    parameter int AW       = $clog2(NUM_ADDR)
) (
    input  logic [NUM_ADDR-1:0] i_Dirty,
    input  logic [AW-1:0]       i_Last,
    output logic                o_Found,
    output logic [AW-1:0]       o_Next
);

    logic [AW-1:0] w_Idx;

    // Walk offsets from farthest to nearest so the nearest dirty address wins.
    always_comb begin
        o_Found = 1'b0;
        o_Next  = '0;
        w_Idx   = '0;
        for (int i = NUM_ADDR; i >= 1; i--) begin
            w_Idx = AW'((int'(i_Last) + i) % NUM_ADDR);
            if (i_Dirty[w_Idx]) begin
                o_Found = 1'b1;
                o_Next  = w_Idx;
            end
        end
    end

endmodule

// File: rtl/tm1638_display_ctrl.sv
// TM1638 shadow buffer + command generator; a write reaches o_Data_Valid 2 cycles later.
// Holds the pending word while i_FIFO_Full is high and leaves a dead cycle after every push.
module tm1638_display_ctrl
    import tm1638_pkg::*;
#(
    parameter int INIT_DELAY_CYCLES = 16,
    parameter int NUM_ADDR          = 16
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic                        i_Wr,
    input  logic [$clog2(NUM_ADDR)-1:0] i_Wr_Addr,
    input  logic [7:0]                  i_Wr_Data,
    input  logic [2:0]                  i_Brightness,
    input  logic                        i_Display_On,
    input  logic                        i_FIFO_Full,
    output logic                        o_Data_Valid,
    output logic [17:0]                 o_Data,
    output logic                        o_Busy
);

    localparam int AW = $clog2(NUM_ADDR);
    localparam int CW = $clog2(INIT_DELAY_CYCLES + 1);

    state_t              r_State;
    state_t              w_Next;
    logic [CW-1:0]       r_Cnt;
    logic [7:0]          r_Buf [NUM_ADDR];
    logic [NUM_ADDR-1:0] r_Dirty;
    logic [NUM_ADDR-1:0] w_Dirty_Set;
    logic [NUM_ADDR-1:0] w_Dirty_Clr;
    logic [AW-1:0]       r_Last;
    logic [3:0]          r_Cfg;
    logic [3:0]          w_Cfg_In;
    logic                r_Cfg_Pend;
    logic [17:0]         r_Data_Last;
    logic [17:0]         w_Word;
    logic                w_Emit_State;
    logic                w_Valid;
    logic                w_Found;
    logic [AW-1:0]       w_Pick;

    rr_picker #(
        .NUM_ADDR (NUM_ADDR),
        .AW       (AW)
    ) u_picker (
        .i_Dirty (r_Dirty),
        .i_Last  (r_Last),
        .o_Found (w_Found),
        .o_Next  (w_Pick)
    );

    assign w_Cfg_In     = {i_Display_On, i_Brightness};
    assign w_Emit_State = (r_State == ST_DATA_CMD) || (r_State == ST_DISP_CTRL) ||
                          (r_State == ST_EMIT);
    assign w_Valid      = w_Emit_State && !i_FIFO_Full;

    always_comb begin
        w_Word = '0;
        case (r_State)
            ST_DATA_CMD:  w_Word = pack_word(KIND_CMD, CMD_DATA_FIXED, 8'h00);
            ST_DISP_CTRL: w_Word = pack_word(KIND_CMD, CMD_DISP_BASE | {4'b0000, r_Cfg}, 8'h00);
            ST_EMIT:      w_Word = pack_word(KIND_ADDR_DATA, CMD_ADDR_BASE | 8'(w_Pick),
                                             r_Buf[w_Pick]);
            default:      w_Word = '0;
        endcase
    end

    always_comb begin
        w_Next = r_State;
        case (r_State)
            ST_INIT:      if (r_Cnt == CW'(INIT_DELAY_CYCLES - 1)) w_Next = ST_DATA_CMD;
            ST_DATA_CMD:  if (!i_FIFO_Full) w_Next = ST_GAP;
            ST_DISP_CTRL: if (!i_FIFO_Full) w_Next = ST_GAP;
            // Config-pending is still set after init, so the first IDLE visit sends display control.
            ST_IDLE: begin
                if (r_Cfg_Pend)    w_Next = ST_DISP_CTRL;
                else if (|r_Dirty) w_Next = ST_EMIT;
            end
            ST_EMIT:      if (!i_FIFO_Full) w_Next = ST_GAP;
            ST_GAP:       w_Next = ST_IDLE;
            default:      w_Next = ST_INIT;
        endcase
    end

    always_comb begin
        w_Dirty_Set = '0;
        w_Dirty_Clr = '0;
        if (i_Wr)
            w_Dirty_Set[i_Wr_Addr] = 1'b1;
        if ((r_State == ST_EMIT) && w_Valid && w_Found)
            w_Dirty_Clr[w_Pick] = 1'b1;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State     <= ST_INIT;
            r_Cnt       <= '0;
            r_Dirty     <= '1;
            r_Last      <= AW'(NUM_ADDR - 1);
            r_Cfg       <= w_Cfg_In;
            r_Cfg_Pend  <= 1'b1;
            r_Data_Last <= '0;
            for (int i = 0; i < NUM_ADDR; i++)
                r_Buf[i] <= 8'h00;
        end else begin
            r_State <= w_Next;
            if (r_State == ST_INIT)
                r_Cnt <= r_Cnt + 1'b1;
            if (i_Wr)
                r_Buf[i_Wr_Addr] <= i_Wr_Data;
            // Set beats clear: a write colliding with its own emit is sent again later.
            r_Dirty <= (r_Dirty & ~w_Dirty_Clr) | w_Dirty_Set;
            if ((r_State == ST_EMIT) && w_Valid)
                r_Last <= w_Pick;
            if (w_Cfg_In != r_Cfg) begin
                r_Cfg      <= w_Cfg_In;
                r_Cfg_Pend <= 1'b1;
            end else if ((r_State == ST_DISP_CTRL) && w_Valid) begin
                r_Cfg_Pend <= 1'b0;
            end
            if (w_Valid)
                r_Data_Last <= w_Word;
        end
    end

    assign o_Data_Valid = w_Valid;
    assign o_Data       = w_Valid ? w_Word : r_Data_Last;
    assign o_Busy       = (r_State == ST_INIT) || (r_State == ST_DATA_CMD) ||
                          r_Cfg_Pend || (|r_Dirty);

endmodule

// File: tb/tb_tm1638_display_ctrl.sv
// Directed bench for tm1638_display_ctrl: init sequence, round-robin, backpressure,
// config priority, write/emit collision and mid-stream reset.
module tb_tm1638_display_ctrl;

    localparam int INIT_DELAY = 16;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic        i_Wr;
    logic [3:0]  i_Wr_Addr;
    logic [7:0]  i_Wr_Data;
    logic [2:0]  i_Brightness;
    logic        i_Display_On;
    logic        i_FIFO_Full;
    logic        o_Data_Valid;
    logic [17:0] o_Data;
    logic        o_Busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_Clk = ~i_Clk;

    tm1638_display_ctrl #(
        .INIT_DELAY_CYCLES (INIT_DELAY),
        .NUM_ADDR          (16)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_Wr         (i_Wr),
        .i_Wr_Addr    (i_Wr_Addr),
        .i_Wr_Data    (i_Wr_Data),
        .i_Brightness (i_Brightness),
        .i_Display_On (i_Display_On),
        .i_FIFO_Full  (i_FIFO_Full),
        .o_Data_Valid (o_Data_Valid),
        .o_Data       (o_Data),
        .o_Busy       (o_Busy)
    );

    // Advance at least one cycle, then wait (bounded) for the next push.
    task automatic get_word(output logic [17:0] w, output int gap, output logic ok);
        gap = 0;
        ok  = 1'b0;
        w   = '0;
        for (int k = 0; k < 400; k++) begin
            @(negedge i_Clk);
            if (o_Data_Valid) begin
                w  = o_Data;
                ok = 1'b1;
                break;
            end
            gap++;
        end
    endtask

    task automatic settle;
        for (int k = 0; k < 2000; k++) begin
            @(negedge i_Clk);
            if (!o_Busy) break;
        end
        n_vec++;
        if (o_Busy !== 1'b0) begin
            n_err++;
            $display("FAIL settle_busy: o_Busy=%b, required 0", o_Busy);
        end
        repeat (3) @(negedge i_Clk);
    endtask

    task automatic test_reset;
        i_Rst = 1'b1; i_Wr = 1'b0; i_Wr_Addr = '0; i_Wr_Data = '0;
        i_Brightness = 3'd7; i_Display_On = 1'b1; i_FIFO_Full = 1'b0;
        repeat (2) @(negedge i_Clk);
        n_vec++;
        if (o_Data_Valid !== 1'b0 || o_Data !== 18'h0 || o_Busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b data=%h busy=%b, required 0/00000/1",
                     o_Data_Valid, o_Data, o_Busy);
        end
        i_Rst = 1'b0;
    endtask

    // Entered at the first sample after the reset edge.
    task automatic test_init_sequence(input logic [7:0] disp);
        logic [17:0] w;
        logic [17:0] exp;
        int          gap;
        logic        ok;
        get_word(w, gap, ok);
        n_vec++;
        if (!ok || w !== {2'b00, 8'h44, 8'h00}) begin
            n_err++;
            $display("FAIL init_data_cmd: got %h (ok=%b), required 04400", w, ok);
        end
        n_vec++;
        if (gap !== INIT_DELAY - 1) begin
            n_err++;
            $display("FAIL init_delay: idle samples %0d, required %0d", gap, INIT_DELAY - 1);
        end
        get_word(w, gap, ok);
        n_vec++;
        if (!ok || w !== {2'b00, disp, 8'h00} || gap < 1) begin
            n_err++;
            $display("FAIL init_disp_ctrl: got %h gap %0d, required %h gap>=1",
                     w, gap, {2'b00, disp, 8'h00});
        end
        for (int a = 0; a < 16; a++) begin
            exp = {2'b01, 8'hC0 | 8'(a), 8'h00};
            get_word(w, gap, ok);
            n_vec++;
            if (!ok || w !== exp || gap < 1) begin
                n_err++;
                $display("FAIL init_blank_%0d: got %h gap %0d, required %h gap>=1", a, w, gap, exp);
            end
        end
        @(negedge i_Clk);
        n_vec++;
        if (o_Busy !== 1'b0) begin
            n_err++;
            $display("FAIL init_busy_drop: o_Busy=%b, required 0", o_Busy);
        end
    endtask

    task automatic test_round_robin;
        logic [17:0] w;
        int          gap;
        logic        ok;
        settle();
        i_Wr = 1'b1; i_Wr_Addr = 4'd3; i_Wr_Data = 8'h3F;
        @(negedge i_Clk);
        i_Wr_Addr = 4'd1; i_Wr_Data = 8'h06;
        @(negedge i_Clk);
        i_Wr = 1'b0;
        n_vec++;
        if (o_Data_Valid !== 1'b1 || o_Data !== {2'b01, 8'hC1, 8'h06}) begin
            n_err++;
            $display("FAIL rr_first_latency: valid=%b data=%h, required 1/%h",
                     o_Data_Valid, o_Data, {2'b01, 8'hC1, 8'h06});
        end
        get_word(w, gap, ok);
        n_vec++;
        if (!ok || w !== {2'b01, 8'hC3, 8'h3F} || gap < 1) begin
            n_err++;
            $display("FAIL rr_second: got %h gap %0d, required %h", w, gap, {2'b01, 8'hC3, 8'h3F});
        end
        @(negedge i_Clk);
        n_vec++;
        if (o_Busy !== 1'b0) begin
            n_err++;
            $display("FAIL rr_busy_drop: o_Busy=%b, required 0", o_Busy);
        end
    endtask

    task automatic test_backpressure;
        int hits = 0;
        settle();
        i_FIFO_Full = 1'b1;
        i_Wr = 1'b1; i_Wr_Addr = 4'd7; i_Wr_Data = 8'h5A;
        @(negedge i_Clk);
        i_Wr = 1'b0;
        repeat (20) begin
            @(negedge i_Clk);
            if (o_Data_Valid) hits++;
        end
        n_vec++;
        if (hits !== 0) begin
            n_err++;
            $display("FAIL bp_no_push_when_full: %0d pushes, required 0", hits);
        end
        i_FIFO_Full = 1'b0;
        #1;
        n_vec++;
        if (o_Data_Valid !== 1'b1 || o_Data !== {2'b01, 8'hC7, 8'h5A}) begin
            n_err++;
            $display("FAIL bp_release_word: valid=%b data=%h, required 1/%h",
                     o_Data_Valid, o_Data, {2'b01, 8'hC7, 8'h5A});
        end
        @(negedge i_Clk);
        n_vec++;
        if (o_Data_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_gap: valid=%b, required 0", o_Data_Valid);
        end
    endtask

    task automatic test_config_priority;
        logic [3:0]  wa [5] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10};
        logic [7:0]  wd [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        logic [17:0] ex [5] = '{18'h1C878, 18'h1CA9A, 18'h1C212, 18'h1C434, 18'h1C656};
        logic [17:0] w;
        int          gap;
        logic        ok;
        settle();
        i_FIFO_Full = 1'b1;
        i_Brightness = 3'd2;
        repeat (2) @(negedge i_Clk);
        for (int i = 0; i < 5; i++) begin
            i_Wr = 1'b1; i_Wr_Addr = wa[i]; i_Wr_Data = wd[i];
            @(negedge i_Clk);
        end
        i_Wr = 1'b0;
        repeat (2) @(negedge i_Clk);
        i_FIFO_Full = 1'b0;
        #1;
        n_vec++;
        if (o_Data_Valid !== 1'b1 || o_Data !== {2'b00, 8'h8A, 8'h00}) begin
            n_err++;
            $display("FAIL cfg_first: valid=%b data=%h, required 1/%h",
                     o_Data_Valid, o_Data, {2'b00, 8'h8A, 8'h00});
        end
        for (int i = 0; i < 5; i++) begin
            get_word(w, gap, ok);
            n_vec++;
            if (!ok || w !== ex[i] || gap < 1) begin
                n_err++;
                $display("FAIL cfg_addr_word_%0d: got %h gap %0d, required %h", i, w, gap, ex[i]);
            end
        end
    endtask

    task automatic test_write_collision;
        logic [17:0] w;
        int          gap;
        logic        ok;
        settle();
        i_Wr = 1'b1; i_Wr_Addr = 4'd5; i_Wr_Data = 8'h11;
        @(negedge i_Clk);
        i_Wr = 1'b0;
        @(negedge i_Clk);
        n_vec++;
        if (o_Data_Valid !== 1'b1 || o_Data !== {2'b01, 8'hC5, 8'h11}) begin
            n_err++;
            $display("FAIL coll_old_data: valid=%b data=%h, required 1/%h",
                     o_Data_Valid, o_Data, {2'b01, 8'hC5, 8'h11});
        end
        i_Wr = 1'b1; i_Wr_Data = 8'h22;
        @(negedge i_Clk);
        i_Wr = 1'b0;
        get_word(w, gap, ok);
        n_vec++;
        if (!ok || w !== {2'b01, 8'hC5, 8'h22}) begin
            n_err++;
            $display("FAIL coll_resend: got %h (ok=%b), required %h", w, ok, {2'b01, 8'hC5, 8'h22});
        end
    endtask

    task automatic test_reset_midstream;
        settle();
        i_FIFO_Full = 1'b1;
        i_Wr = 1'b1; i_Wr_Addr = 4'd9; i_Wr_Data = 8'h99;
        @(negedge i_Clk);
        i_Wr = 1'b0;
        repeat (3) @(negedge i_Clk);
        n_vec++;
        if (o_Data_Valid !== 1'b0 || o_Busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pending: valid=%b busy=%b, required 0/1", o_Data_Valid, o_Busy);
        end
        i_Rst = 1'b1;
        @(negedge i_Clk);
        i_Rst = 1'b0;
        i_FIFO_Full = 1'b0;
        n_vec++;
        if (o_Data_Valid !== 1'b0 || o_Data !== 18'h0 || o_Busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_outputs: valid=%b data=%h busy=%b, required 0/00000/1",
                     o_Data_Valid, o_Data, o_Busy);
        end
        test_init_sequence(8'h8A);
    endtask

    initial begin
        test_reset();
        test_init_sequence(8'h8F);
        test_round_robin();
        test_backpressure();
        test_config_priority();
        test_write_collision();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
